// File: rtl/manch_tdm_pkg.sv
// Shared constants and helpers for the Manchester TDM scheduler.
package manch_tdm_pkg;

    localparam logic IDLE_BIT     = 1'b0;
    localparam int   NCH_DEF      = 2;
    localparam int   DW_DEF       = 8;
    localparam int   SLOT_LEN_DEF = 2;
    localparam int   UCW          = 8;

    function automatic logic [UCW-1:0] sat_inc(input logic [UCW-1:0] val);
        if (val == {UCW{1'b1}}) begin
            sat_inc = val;
        end else begin
            sat_inc = val + UCW'(1);
        end
    endfunction

endpackage

// File: rtl/manch_tdm_chan.sv
// One requester channel: holding shift register, bit counter, loaded flag and ready.
module manch_tdm_chan
    import manch_tdm_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [DW-1:0] data,
    input  logic          shift,
    output logic          ready,
    output logic          loaded,
    output logic          msb
);

    localparam int CW = $clog2(DW);

    logic [DW-1:0] shreg_r;
    logic [CW-1:0] cnt_r;

    // Load on handshake; shift out one bit per owned slot, releasing after the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= '0;
            cnt_r   <= '0;
            loaded  <= 1'b0;
            ready   <= 1'b1;
        end else if (valid && ready) begin
            shreg_r <= data;
            cnt_r   <= '0;
            loaded  <= 1'b1;
            ready   <= 1'b0;
        end else if (shift && loaded) begin
            shreg_r <= {shreg_r[DW-2:0], 1'b0};
            cnt_r   <= cnt_r + CW'(1);
            if (cnt_r == CW'(DW - 1)) begin
                loaded <= 1'b0;
                ready  <= 1'b1;
            end else begin
                loaded <= 1'b1;
                ready  <= 1'b0;
            end
        end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
            loaded  <= loaded;
            ready   <= ready;
        end
    end

    assign msb = shreg_r[DW-1];

endmodule

// File: rtl/manch_tdm_sched.sv
// TDM slot scheduler feeding a differential Manchester encoder: sync slot then one slot per channel.
// Define MANCH_TDM_UNDERRUN_EN to add the saturating underrun_cnt output.
module manch_tdm_sched
    import manch_tdm_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int DW       = DW_DEF,
    parameter int SLOT_LEN = SLOT_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NCH-1:0]             ch_valid,
    input  logic [NCH*DW-1:0]          ch_data,
    output logic [NCH-1:0]             ch_ready,
    output logic                       y,
    output logic                       slot_stb,
    output logic                       frame_start,
    output logic [$clog2(NCH+1)-1:0]   slot_idx
`ifdef MANCH_TDM_UNDERRUN_EN
    ,
    output logic [UCW-1:0]             underrun_cnt
`endif
);

    localparam int SW = $clog2(NCH + 1);
    localparam int TW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

    logic [TW-1:0]  timer_r;
    logic           restart_r;
    logic           sync_bit_r;
    logic           bnd_s;
    logic           ny_s;
    logic [SW-1:0]  nslot_s;
    logic [NCH-1:0] sel_s;
    logic [NCH-1:0] shift_s;
    logic [NCH-1:0] loaded_s;
    logic [NCH-1:0] msb_s;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        manch_tdm_chan #(.DW(DW)) u_chan (
            .clk    (clk),
            .rst    (rst),
            .valid  (ch_valid[i]),
            .data   (ch_data[i*DW +: DW]),
            .shift  (shift_s[i]),
            .ready  (ch_ready[i]),
            .loaded (loaded_s[i]),
            .msb    (msb_s[i])
        );
    end

    // Boundary detection, next-slot selection and the bit that slot would carry.
    always_comb begin
        bnd_s = en & (restart_r | (timer_r == TW'(SLOT_LEN - 1)));
        if (restart_r || (slot_idx == SW'(NCH))) begin
            nslot_s = '0;
        end else begin
            nslot_s = slot_idx + SW'(1);
        end
        ny_s  = sync_bit_r;
        sel_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (nslot_s == SW'(i + 1)) begin
                sel_s[i] = 1'b1;
                if (loaded_s[i]) begin
                    ny_s = msb_s[i];
                end else begin
                    ny_s = IDLE_BIT;
                end
            end else begin
                sel_s[i] = 1'b0;
            end
        end
        shift_s = sel_s & {NCH{bnd_s}};
    end

    // Slot timer and registered serial outputs; disabling parks the frame at slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r     <= '0;
            restart_r   <= 1'b1;
            sync_bit_r  <= 1'b0;
            y           <= 1'b0;
            slot_idx    <= '0;
            slot_stb    <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            timer_r     <= '0;
            restart_r   <= 1'b1;
            sync_bit_r  <= sync_bit_r;
            y           <= 1'b0;
            slot_idx    <= '0;
            slot_stb    <= 1'b0;
            frame_start <= 1'b0;
        end else if (bnd_s) begin
            timer_r     <= '0;
            restart_r   <= 1'b0;
            y           <= ny_s;
            slot_idx    <= nslot_s;
            slot_stb    <= 1'b1;
            frame_start <= (nslot_s == '0);
            if (nslot_s == '0) begin
                sync_bit_r <= ~sync_bit_r;
            end else begin
                sync_bit_r <= sync_bit_r;
            end
        end else begin
            timer_r     <= timer_r + TW'(1);
            restart_r   <= 1'b0;
            sync_bit_r  <= sync_bit_r;
            y           <= y;
            slot_idx    <= slot_idx;
            slot_stb    <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef MANCH_TDM_UNDERRUN_EN
    logic idle_s;

    // A data slot is idle when its channel has nothing loaded at the boundary.
    always_comb begin
        idle_s = bnd_s & (nslot_s != '0) & ((sel_s & loaded_s) == '0);
    end

    // Saturating count of idle data slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (idle_s) begin
            underrun_cnt <= sat_inc(underrun_cnt);
        end else begin
            underrun_cnt <= underrun_cnt;
        end
    end
`endif

endmodule

// File: doc/manch_tdm_sched.md
MANCH_TDM_SCHED -- requirements
Module: manch_tdm_sched

Interface
REQ-001 Parameter NCH, default 2: number of requester channels, 1..7.
REQ-002 Parameter DW, default 8: word width per channel, 2..16.
REQ-003 Parameter SLOT_LEN, default 2: clk cycles per TDM slot, at least 1.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  scheduler run enable.
REQ-007 ch_valid  input  NCH  per-channel word valid.
REQ-008 ch_data  input  NCH*DW  per-channel word; channel i occupies bits [i*DW +: DW].
REQ-009 ch_ready  output  NCH  per-channel buffer empty; accepts the word.
REQ-010 y  output  1  serial TDM bit to the differential Manchester encoder d input.
REQ-011 slot_stb  output  1  one-cycle pulse; y and slot_idx took new values this cycle.
REQ-012 frame_start  output  1  one-cycle pulse coincident with slot_stb when slot_idx==0.
REQ-013 slot_idx  output  $clog2(NCH+1)  current slot; 0 = sync, k = channel k-1.
REQ-014 underrun_cnt  output  8  idle data-slot counter; present only with MANCH_TDM_UNDERRUN_EN.

Function
REQ-015 Frame = NCH+1 slots of SLOT_LEN cycles each; slot order is 0,1..NCH, then wraps to 0.
REQ-016 Slot boundary: while en=1, a slot timer counts 0..SLOT_LEN-1; a boundary occurs on the first en=1 cycle after disable/reset and on every cycle where the timer==SLOT_LEN-1.
REQ-017 On a boundary, y, slot_idx, slot_stb and frame_start register together; y holds for SLOT_LEN cycles.
REQ-018 Sync slot: y = sync_bit; sync_bit toggles after each sync slot, giving 0,1,0,1... per frame.
REQ-019 Handshake: a transfer occurs when ch_valid[i]&ch_ready[i]; ch_ready[i] = ~loaded[i], registered.
REQ-020 Transfer effects: the word loads into channel i's shift register with bit count 0; loaded[i]=1 from the next cycle.
REQ-021 Data slot k with loaded[k-1]=1: y = MSB of the shift register; the register shifts left and the count increments.
REQ-022 After the DW-th bit is emitted, loaded clears on that boundary cycle, so ch_ready rises on the following cycle.
REQ-023 Data slot with loaded=0: y = IDLE_BIT (0).
REQ-024 Latency: a word accepted at cycle t emits its MSB at the first boundary of its slot at cycle >= t+2.
REQ-025 Bits are MSB first, one bit per frame per channel; channels are fully independent.
REQ-026 en=0 handling:
- no boundaries occur; slot_stb=0 and frame_start=0;
- y and slot_idx are forced to 0 on the next cycle;
- the next enabled slot is slot 0;
- partial words and sync_bit are retained;
- handshakes remain legal.

Reset
REQ-027 On rst, on the next edge: y=0, slot_stb=0, frame_start=0, slot_idx=0, ch_ready all 1, sync_bit=0, slot timer=0, all loaded=0, shift registers=0, underrun_cnt=0.
REQ-028 rst has priority over en and over any transfer in the same cycle.
REQ-029 rst mid-word discards the word; no further bits of it are emitted.

Configuration
REQ-030 The macro MANCH_TDM_UNDERRUN_EN compiles in underrun_cnt.
REQ-031 With the macro defined, underrun_cnt increments, saturating at 255, on each REQ-023 idle data slot.
REQ-032 Without the macro, the underrun_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-033 Package manch_tdm_pkg shall hold:
- IDLE_BIT;
- default NCH, DW and SLOT_LEN;
- the underrun counter width of 8.
REQ-034 Sub-module manch_tdm_chan, instantiated NCH times, shall hold one channel's loaded flag, shift register, bit counter and ready logic.

Verification
REQ-035 Use NCH=2, DW=8, SLOT_LEN=2. After rst, en=1 with no valid for 2 frames: y per slot is 0,0,0,1,0,0; frame_start occurs every 6 cycles; ch_ready=2'b11.
REQ-036 Load ch0=0xA5: over 8 frames, the slot-1 bits are 1,0,1,0,0,1,0,1; ch_ready[0] is low until the cycle after the 8th bit.
REQ-037 Load ch0=0xFF and ch1=0x00 in the same cycle: slot 1 carries 1 and slot 2 carries 0 for 8 frames; both ready flags rise in the same frame.
REQ-038 Drop en for 5 cycles after 3 bits of ch1=0xC3 have been sent:
- the first enabled slot is 0;
- the remaining bits are 0,0,0,1,1;
- sync continues the alternation.
REQ-039 Assert rst after 4 bits of ch0=0x5A: on the next cycle, ch_ready=2'b11, y=0 and slot_idx=0; the later output is the idle pattern only.
REQ-040 With MANCH_TDM_UNDERRUN_EN, run 130 idle frames: underrun_cnt=255 and holds; without the macro, the design elaborates without the port.
